// File: rtl/dsm_decimator_if.sv
// Sample-in / decimated-word-out bundle between a DSM stream source and the sinc3 decoder.
// Latency: none, wires only.
// Backpressure: none; the source qualifies samples with In_Valid, the decoder strobes Out_Valid.
interface dsm_decimator_if #(
    parameter int LOG2R = 7,
    parameter int IN_W  = 5,
    parameter int OUT_W = 7
);
    logic signed [IN_W-1:0]            In_Data;
    logic                              In_Valid;
    logic        [OUT_W-1:0]           Out_Data;
    logic signed [IN_W+3*LOG2R-1:0]    Out_Full;
    logic                              Out_Valid;
    logic                              Settled;

    modport master (
        output In_Data, In_Valid,
        input  Out_Data, Out_Full, Out_Valid, Settled
    );

    modport slave (
        input  In_Data, In_Valid,
        output Out_Data, Out_Full, Out_Valid, Settled
    );
endinterface

// File: rtl/dsm_decimator.sv
// Third-order CIC (sinc3) decimator rebuilding the fractional control word from a MASH 1-1-1 stream.
// Latency: Out_Valid/Out_Data/Out_Full one cycle after every 2^LOG2R-th valid sample.
// Backpressure: none; one sample accepted per In_Valid cycle, output strobes cannot be stalled.
module dsm_decimator #(
    parameter int LOG2R = 7,
    parameter int IN_W  = 5,
    parameter int OUT_W = 7
) (
    input  logic              Clk,
    input  logic              reset,
    dsm_decimator_if.slave    bus
);
    localparam int W     = IN_W + 3*LOG2R;
    localparam int SHIFT = 2*LOG2R;
    localparam logic signed [W-1:0] OUT_MAX = {{(W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic signed [W-1:0] x;
    logic signed [W-1:0] i1, i2, i3;
    logic signed [W-1:0] i1_nx, i2_nx, i3_nx;
    logic signed [W-1:0] d1, d2, d3;
    logic signed [W-1:0] c1, c2, c3;
    logic signed [W-1:0] c3_shr;
    logic [LOG2R-1:0]    cnt;
    logic [1:0]          dec_cnt;
    logic                dec_evt;
    logic [OUT_W-1:0]    data_sat;

    // Integrator cascade, comb differences and output scaling, all within one cycle.
    // Arithmetic wraps modulo 2^W on purpose: the comb cancels the integrator wrap.
    always_comb begin
        x       = {{(W-IN_W){bus.In_Data[IN_W-1]}}, bus.In_Data};
        i1_nx   = i1 + x;
        i2_nx   = i2 + i1_nx;
        i3_nx   = i3 + i2_nx;
        dec_evt = bus.In_Valid && (cnt == {LOG2R{1'b1}});
        c1      = i3_nx - d1;
        c2      = c1 - d2;
        c3      = c2 - d3;
        // Divide by R^2 with floor, then clamp into the unsigned output range.
        c3_shr  = c3 >>> SHIFT;
        if (c3_shr[W-1]) begin
            data_sat = '0;
        end else if (c3_shr > OUT_MAX) begin
            data_sat = '1;
        end else begin
            data_sat = c3_shr[OUT_W-1:0];
        end
    end

    // Integrators and the in-block sample counter advance only on qualified samples.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            cnt <= '0;
        end else if (bus.In_Valid) begin
            i1  <= i1_nx;
            i2  <= i2_nx;
            i3  <= i3_nx;
            cnt <= cnt + 1'b1;
        end
    end

    // Comb delay line and the held output words update only on a decimation event.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            d1           <= '0;
            d2           <= '0;
            d3           <= '0;
            bus.Out_Full <= '0;
            bus.Out_Data <= '0;
        end else if (dec_evt) begin
            d1           <= i3_nx;
            d2           <= c1;
            d3           <= c2;
            bus.Out_Full <= c3;
            bus.Out_Data <= data_sat;
        end
    end

    // Output strobe, saturating block count, and the sticky settle flag raised with the 3rd strobe.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            bus.Out_Valid <= 1'b0;
            bus.Settled   <= 1'b0;
            dec_cnt       <= 2'd0;
        end else begin
            bus.Out_Valid <= dec_evt;
            if (dec_evt && (dec_cnt != 2'd3)) begin
                dec_cnt <= dec_cnt + 2'd1;
            end
            if (dec_evt && (dec_cnt >= 2'd2)) begin
                bus.Settled <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dsm_decimator.sv
module tb_dsm_decimator;
    localparam int LOG2R = 7;
    localparam int IN_W  = 5;
    localparam int OUT_W = 7;
    localparam int R     = 1 << LOG2R;
    localparam int HLEN  = 3*R - 2;

    logic Clk   = 1'b0;
    logic reset = 1'b0;

    dsm_decimator_if #(.LOG2R(LOG2R), .IN_W(IN_W), .OUT_W(OUT_W)) bus();

    dsm_decimator #(.LOG2R(LOG2R), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int     checks = 0;
    int     passes = 0;
    longint h[HLEN];
    longint hist[$];
    longint last_full = 0;

    // Impulse response of the sinc3 filter: three length-R boxcars convolved.
    task automatic build_h();
        longint h2[2*R-1];
        foreach (h2[i]) h2[i] = 0;
        foreach (h[i]) h[i] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                h2[a+b] += 1;
        for (int a = 0; a < 2*R-1; a++)
            for (int b = 0; b < R; b++)
                h[a+b] += h2[a];
    endtask

    // Filter output after the most recent sample, from the whole history since reset.
    function automatic longint model_full();
        longint s = 0;
        int n = hist.size();
        for (int i = 0; i < HLEN && i < n; i++)
            s += h[i] * hist[n-1-i];
        return s;
    endfunction

    // Reconstructed word: floor(full / R^2) clamped to 0..2^OUT_W-1.
    function automatic int exp_data(input longint f);
        longint rr = longint'(R) * R;
        longint q;
        if (f >= 0) q = f / rr;
        else        q = -((-f + rr - 1) / rr);
        if (q < 0) return 0;
        if (q > (1 << OUT_W) - 1) return (1 << OUT_W) - 1;
        return int'(q);
    endfunction

    // Drive one cycle and return what the outputs must show just after that edge.
    task automatic apply(input int x, input bit v, output bit ev, output bit es, output longint ef);
        bus.In_Data  = IN_W'(x);
        bus.In_Valid = v;
        @(posedge Clk);
        #1;
        ev = 1'b0;
        if (v) begin
            hist.push_back(longint'(x));
            if (hist.size() % R == 0) begin
                ev = 1'b1;
                last_full = model_full();
            end
        end
        ef = last_full;
        es = (hist.size() >= 3*R);
    endtask

    task automatic do_reset();
        bus.In_Valid = 1'b0;
        bus.In_Data  = '0;
        @(posedge Clk);
        #3 reset = 1'b0;
        #10 reset = 1'b1;
        hist.delete();
        last_full = 0;
    endtask

    task automatic test_reset();
        bus.In_Valid = 1'b0;
        bus.In_Data  = '0;
        #12;
        checks++; if (bus.Out_Valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.Out_Valid); else passes++;
        checks++; if (bus.Settled !== 1'b0) $display("FAIL reset_settled got %b want 0", bus.Settled); else passes++;
        checks++; if (bus.Out_Full !== '0) $display("FAIL reset_full got %0d want 0", $signed(bus.Out_Full)); else passes++;
        checks++; if (bus.Out_Data !== '0) $display("FAIL reset_data got %0d want 0", bus.Out_Data); else passes++;
        #1 reset = 1'b1;
        hist.delete();
        last_full = 0;
    endtask

    task automatic test_zero();
        bit ev, es; longint ef;
        do_reset();
        for (int n = 0; n < 3*R; n++) begin
            apply(0, 1'b1, ev, es, ef);
            checks++; if ({bus.Out_Valid, bus.Settled} !== {ev, es}) $display("FAIL zero_strobe n=%0d got v/s %b%b want %b%b", n, bus.Out_Valid, bus.Settled, ev, es); else passes++;
            checks++; if ($signed(bus.Out_Full) !== 0) $display("FAIL zero_full n=%0d got %0d want 0", n, $signed(bus.Out_Full)); else passes++;
            checks++; if (bus.Out_Data !== '0) $display("FAIL zero_data n=%0d got %0d want 0", n, bus.Out_Data); else passes++;
        end
    endtask

    task automatic test_half_scale();
        bit ev, es; longint ef; int strobes = 0;
        do_reset();
        for (int n = 0; n < 4*R; n++) begin
            apply((n % 2 == 0) ? 1 : 0, 1'b1, ev, es, ef);
            checks++; if ({bus.Out_Valid, bus.Settled} !== {ev, es}) $display("FAIL half_strobe n=%0d got v/s %b%b want %b%b", n, bus.Out_Valid, bus.Settled, ev, es); else passes++;
            checks++; if ($signed(bus.Out_Full) !== ef) $display("FAIL half_full n=%0d got %0d want %0d", n, $signed(bus.Out_Full), ef); else passes++;
            checks++; if (bus.Out_Data !== OUT_W'(exp_data(ef))) $display("FAIL half_data n=%0d got %0d want %0d", n, bus.Out_Data, exp_data(ef)); else passes++;
            if (ev) begin
                strobes++;
                if (strobes >= 3) begin
                    checks++; if ($signed(bus.Out_Full) !== 1048576) $display("FAIL half_full_settled got %0d want 1048576", $signed(bus.Out_Full)); else passes++;
                    checks++; if (bus.Out_Data !== 7'd64) $display("FAIL half_data_settled got %0d want 64", bus.Out_Data); else passes++;
                end
            end
        end
    endtask

    task automatic test_saturation(input int val, input longint full_c, input int data_c);
        bit ev, es; longint ef; int strobes = 0;
        do_reset();
        for (int n = 0; n < 4*R; n++) begin
            apply(val, 1'b1, ev, es, ef);
            checks++; if ({bus.Out_Valid, bus.Settled} !== {ev, es}) $display("FAIL sat%0d_strobe n=%0d got v/s %b%b want %b%b", val, n, bus.Out_Valid, bus.Settled, ev, es); else passes++;
            checks++; if ($signed(bus.Out_Full) !== ef) $display("FAIL sat%0d_full n=%0d got %0d want %0d", val, n, $signed(bus.Out_Full), ef); else passes++;
            checks++; if (bus.Out_Data !== OUT_W'(exp_data(ef))) $display("FAIL sat%0d_data n=%0d got %0d want %0d", val, n, bus.Out_Data, exp_data(ef)); else passes++;
            if (ev) begin
                strobes++;
                if (strobes >= 3) begin
                    checks++; if ($signed(bus.Out_Full) !== full_c) $display("FAIL sat%0d_full_settled got %0d want %0d", val, $signed(bus.Out_Full), full_c); else passes++;
                    checks++; if (bus.Out_Data !== OUT_W'(data_c)) $display("FAIL sat%0d_data_settled got %0d want %0d", val, bus.Out_Data, data_c); else passes++;
                end
            end
        end
    endtask

    task automatic test_valid_gaps();
        bit ev, es, v; longint ef; int strobes = 0; int n = 0; int x;
        do_reset();
        for (int cyc = 0; cyc < 12*R && n < 4*R; cyc++) begin
            v = ($urandom_range(0, 99) >= 30);
            x = v ? ((n % 2 == 0) ? 1 : 0) : $urandom_range(0, 7) - 3;
            apply(x, v, ev, es, ef);
            if (v) n++;
            checks++; if ({bus.Out_Valid, bus.Settled} !== {ev, es}) $display("FAIL gap_strobe cyc=%0d got v/s %b%b want %b%b", cyc, bus.Out_Valid, bus.Settled, ev, es); else passes++;
            checks++; if ($signed(bus.Out_Full) !== ef) $display("FAIL gap_full cyc=%0d got %0d want %0d", cyc, $signed(bus.Out_Full), ef); else passes++;
            checks++; if (bus.Out_Data !== OUT_W'(exp_data(ef))) $display("FAIL gap_data cyc=%0d got %0d want %0d", cyc, bus.Out_Data, exp_data(ef)); else passes++;
            if (ev) begin
                strobes++;
                if (strobes >= 3) begin
                    checks++; if ($signed(bus.Out_Full) !== 1048576) $display("FAIL gap_full_settled got %0d want 1048576", $signed(bus.Out_Full)); else passes++;
                end
            end
        end
        checks++; if (strobes !== 4) $display("FAIL gap_strobe_count got %0d want 4 (valid samples %0d)", strobes, n); else passes++;
    endtask

    task automatic test_reset_mid();
        bit ev, es; longint ef;
        do_reset();
        for (int n = 0; n < 3*R + 50; n++) begin
            apply(1, 1'b1, ev, es, ef);
            checks++; if ({bus.Out_Valid, bus.Settled} !== {ev, es}) $display("FAIL rstmid_pre_strobe n=%0d got v/s %b%b want %b%b", n, bus.Out_Valid, bus.Settled, ev, es); else passes++;
        end
        #3 reset = 1'b0;
        #1;
        checks++; if (bus.Settled !== 1'b0) $display("FAIL rstmid_settled got %b want 0", bus.Settled); else passes++;
        checks++; if (bus.Out_Full !== '0) $display("FAIL rstmid_full got %0d want 0", $signed(bus.Out_Full)); else passes++;
        checks++; if (bus.Out_Data !== '0) $display("FAIL rstmid_data got %0d want 0", bus.Out_Data); else passes++;
        checks++; if (bus.Out_Valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", bus.Out_Valid); else passes++;
        #10 reset = 1'b1;
        hist.delete();
        last_full = 0;
        for (int n = 0; n < R + 2; n++) begin
            apply(1, 1'b1, ev, es, ef);
            checks++; if ({bus.Out_Valid, bus.Settled} !== {ev, es}) $display("FAIL rstmid_post_strobe n=%0d got v/s %b%b want %b%b", n, bus.Out_Valid, bus.Settled, ev, es); else passes++;
            checks++; if ($signed(bus.Out_Full) !== ef) $display("FAIL rstmid_post_full n=%0d got %0d want %0d", n, $signed(bus.Out_Full), ef); else passes++;
        end
    endtask

    // MASH 1-1-1 source with 7-bit accumulators feeding the decoder every cycle.
    task automatic test_end_to_end(input int k);
        bit ev, es; longint ef; int strobes = 0; int sum = 0; int lo;
        int a1 = 0, a2 = 0, a3 = 0, c1, c2, c3, c2p = 0, c3p = 0, c3pp = 0, y;
        lo = (k > 0) ? k - 1 : 0;
        do_reset();
        for (int n = 0; n < 19*R; n++) begin
            a1 += k;  c1 = (a1 >= R) ? 1 : 0; a1 -= c1 * R;
            a2 += a1; c2 = (a2 >= R) ? 1 : 0; a2 -= c2 * R;
            a3 += a2; c3 = (a3 >= R) ? 1 : 0; a3 -= c3 * R;
            y = c1 + c2 - c2p + c3 - 2*c3p + c3pp;
            c3pp = c3p; c3p = c3; c2p = c2;
            apply(y, 1'b1, ev, es, ef);
            checks++; if ({bus.Out_Valid, bus.Settled} !== {ev, es}) $display("FAIL e2e%0d_strobe n=%0d got v/s %b%b want %b%b", k, n, bus.Out_Valid, bus.Settled, ev, es); else passes++;
            if (ev) begin
                strobes++;
                checks++; if ($signed(bus.Out_Full) !== ef) $display("FAIL e2e%0d_full n=%0d got %0d want %0d", k, n, $signed(bus.Out_Full), ef); else passes++;
                checks++; if (bus.Out_Data !== OUT_W'(exp_data(ef))) $display("FAIL e2e%0d_data n=%0d got %0d want %0d", k, n, bus.Out_Data, exp_data(ef)); else passes++;
                if (strobes > 3) begin
                    checks++; if (int'(bus.Out_Data) < lo || int'(bus.Out_Data) > k) $display("FAIL e2e%0d_range got %0d want %0d..%0d", k, bus.Out_Data, lo, k); else passes++;
                    sum += int'(bus.Out_Data);
                end
            end
        end
        checks++; if ((2*sum + 16) / 32 !== k) $display("FAIL e2e%0d_mean got sum %0d over 16, want mean rounding to %0d", k, sum, k); else passes++;
    endtask

    initial begin
        build_h();
        test_reset();
        test_zero();
        test_half_scale();
        test_saturation(1, 2097152, 127);
        test_saturation(-1, -2097152, 0);
        test_valid_gaps();
        test_reset_mid();
        test_end_to_end(37);
        test_end_to_end(0);
        test_end_to_end(1);
        test_end_to_end(127);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
